// File: rtl/pe_bit_sparse_mac.sv
// pe_bit_sparse_mac
//   Leaf processing element of the bit-sparsity accelerator. Each cycle, it
//   takes NUM_LANES term pairs. Each term is given as a sign and a
//   power-of-two exponent. For each lane it forms the product
//   +/-2^(AExp+BExp), and lanes flagged invalid contribute zero. The lane
//   products are summed and added into a registered two's-complement
//   accumulator.
//
//   Optional build macro: PE_ACC_SATURATE_EN
//     defined   -> accumulation saturates at the ACC_W signed limits
//     undefined -> accumulation wraps modulo 2^ACC_W
//
// Ports
//   CLK           in   rising-edge clock
//   RSTN          in   synchronous reset, active HIGH (legacy name kept)
//   AExps         in   NUM_LANES*EXP_W, lane i = AExps[i*EXP_W +: EXP_W]
//   ASigns        in   NUM_LANES, lane i sign of A (1 = negative)
//   BExps         in   NUM_LANES*EXP_W, lane i = BExps[i*EXP_W +: EXP_W]
//   BSigns        in   NUM_LANES, lane i sign of B (1 = negative)
//   IsInvalidPair in   NUM_LANES, lane i = 1 -> lane contributes 0
//   RESULT        out  ACC_W, accumulator register
module pe_bit_sparse_mac #(
  parameter int unsigned NUM_LANES = 16,
  parameter int unsigned EXP_W     = 3,
  parameter int unsigned ACC_W     = 22
) (
  input  logic                           CLK,
  input  logic                           RSTN,
  input  logic [NUM_LANES*EXP_W-1:0]     AExps,
  input  logic [NUM_LANES-1:0]           ASigns,
  input  logic [NUM_LANES*EXP_W-1:0]     BExps,
  input  logic [NUM_LANES-1:0]           BSigns,
  input  logic [NUM_LANES-1:0]           IsInvalidPair,
  output logic [ACC_W-1:0]               RESULT
);

  localparam logic [ACC_W-1:0] ONE = {{(ACC_W-1){1'b0}}, 1'b1};

  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] sum;
  logic [ACC_W-1:0] raw;
  logic [ACC_W-1:0] next_acc;
  logic [EXP_W:0]   e;
  logic [ACC_W-1:0] mag;
  logic [ACC_W-1:0] term;

  // Lane products and their sum. Exponent 0 means 2^0 = 1. A lane
  // contributes zero only when it is flagged invalid.
  always_comb begin
    sum  = '0;
    e    = '0;
    mag  = '0;
    term = '0;
    for (int unsigned i = 0; i < NUM_LANES; i++) begin
      e    = {1'b0, AExps[i*EXP_W +: EXP_W]} + {1'b0, BExps[i*EXP_W +: EXP_W]};
      mag  = ONE << e;
      term = (ASigns[i] ^ BSigns[i]) ? (~mag + ONE) : mag;
      if (!IsInvalidPair[i])
        sum = sum + term;
    end
  end

  assign raw = acc + sum;

`ifdef PE_ACC_SATURATE_EN
  // A signed overflow occurs only when both operands have the same sign and
  // the result has the other sign. The operand sign then gives the
  // direction of the clamp.
  logic ovf_pos;
  logic ovf_neg;
  assign ovf_pos = !acc[ACC_W-1] && !sum[ACC_W-1] &&  raw[ACC_W-1];
  assign ovf_neg =  acc[ACC_W-1] &&  sum[ACC_W-1] && !raw[ACC_W-1];

  always_comb begin
    next_acc = raw;
    if (ovf_pos)
      next_acc = {1'b0, {(ACC_W-1){1'b1}}};
    else if (ovf_neg)
      next_acc = {1'b1, {(ACC_W-1){1'b0}}};
  end
`else
  assign next_acc = raw;
`endif

  always_ff @(posedge CLK) begin
    if (RSTN)
      acc <= '0;
    else
      acc <= next_acc;
  end

  assign RESULT = acc;

endmodule

// File: tb/tb_pe_bit_sparse_mac.sv
module tb_pe_bit_sparse_mac;

  localparam int NL  = 16;
  localparam int EW  = 3;
  localparam int AW  = 22;

  logic                 CLK;
  logic                 RSTN;
  logic [NL*EW-1:0]     AExps;
  logic [NL-1:0]        ASigns;
  logic [NL*EW-1:0]     BExps;
  logic [NL-1:0]        BSigns;
  logic [NL-1:0]        IsInvalidPair;
  logic [AW-1:0]        RESULT;

  pe_bit_sparse_mac #(.NUM_LANES(NL), .EXP_W(EW), .ACC_W(AW)) dut (
    .CLK(CLK),
    .RSTN(RSTN),
    .AExps(AExps),
    .ASigns(ASigns),
    .BExps(BExps),
    .BSigns(BSigns),
    .IsInvalidPair(IsInvalidPair),
    .RESULT(RESULT)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Lane-level stimulus, kept as plain arrays
  int ae [NL];
  int be [NL];
  int as_ [NL];
  int bs [NL];
  int inv [NL];

  longint model_acc;
  longint expq [$];
  string  nameq [$];
  int     checks;
  int     errors;
  bit     done;

  localparam longint HALF = longint'(1) << (AW - 1);
  localparam longint FULL = longint'(1) << AW;

  // Reference model: value of the accumulator after one edge
  function automatic longint model_step(input bit rst, input longint acc);
    longint s;
    longint n;
    if (rst) return 0;
    s = 0;
    for (int i = 0; i < NL; i++)
      if (inv[i] == 0)
        s += ((as_[i] ^ bs[i]) != 0 ? -1 : 1) * (longint'(1) << (ae[i] + be[i]));
    n = acc + s;
`ifdef PE_ACC_SATURATE_EN
    if (n > HALF - 1) n = HALF - 1;
    if (n < -HALF) n = -HALF;
`else
    n = ((n % FULL) + FULL) % FULL;
    if (n >= HALF) n -= FULL;
`endif
    return n;
  endfunction

  // Drive one cycle of stimulus and push the value expected after the next edge
  task automatic drive(input bit rst, input string name);
    for (int i = 0; i < NL; i++) begin
      AExps[i*EW +: EW] = EW'(ae[i]);
      BExps[i*EW +: EW] = EW'(be[i]);
      ASigns[i]         = as_[i][0];
      BSigns[i]         = bs[i][0];
      IsInvalidPair[i]  = inv[i][0];
    end
    RSTN      = rst;
    model_acc = model_step(rst, model_acc);
    expq.push_back(model_acc);
    nameq.push_back(name);
  endtask

  task automatic set_all(input int a, input int b, input int sa, input int sb, input int iv);
    for (int i = 0; i < NL; i++) begin
      ae[i] = a; be[i] = b; as_[i] = sa; bs[i] = sb; inv[i] = iv;
    end
  endtask

  task automatic scenario1();
    set_all(0, 0, 0, 0, 0);
    ae[0]  = 2; be[0]  = 1;
    ae[1]  = 4; be[1]  = 1; as_[1] = 1;
    ae[15] = 4; be[15] = 4; as_[15] = 1; bs[15] = 1;
  endtask

  task automatic randomize_lanes();
    for (int i = 0; i < NL; i++) begin
      ae[i]  = int'($urandom_range(7));
      be[i]  = int'($urandom_range(7));
      as_[i] = int'($urandom_range(1));
      bs[i]  = int'($urandom_range(1));
      inv[i] = ($urandom_range(3) == 0) ? 1 : 0;
    end
  endtask

  // Monitor: RESULT is valid every cycle, so compare just after each edge
  initial begin
    longint exp_v;
    longint got;
    string  nm;
    checks = 0;
    errors = 0;
    forever begin
      @(posedge CLK);
      #1;
      if (expq.size() > 0) begin
        exp_v = expq.pop_front();
        nm    = nameq.pop_front();
        got   = longint'($signed(RESULT));
        checks++;
        if (got != exp_v) begin
          errors++;
          $display("FAIL %s: RESULT got %0d (0x%06h) expected %0d", nm, got, RESULT, exp_v);
        end
      end
    end
  end

  initial begin
    int to;
    done      = 1'b0;
    model_acc = 0;

    // Reset with arbitrary inputs
    randomize_lanes();
    drive(1'b1, "reset");
    @(negedge CLK);

    // Mixed signs, no invalid lanes: +245
    scenario1();
    drive(1'b0, "mixed_245");
    @(negedge CLK);

    // Lane15 A sign positive: sum -267 -> -22
    scenario1();
    as_[15] = 0;
    drive(1'b0, "mixed_m22");
    @(negedge CLK);

    // Lanes 2..14 masked: sum 232 -> 210
    scenario1();
    for (int i = 2; i <= 14; i++) inv[i] = 1;
    drive(1'b0, "masked_210");
    @(negedge CLK);

    // All lanes invalid: value holds
    for (int k = 0; k < 3; k++) begin
      randomize_lanes();
      for (int i = 0; i < NL; i++) inv[i] = 1;
      drive(1'b0, "all_invalid_hold");
      @(negedge CLK);
    end

    // Mid-operation reset discards the value
    scenario1();
    drive(1'b1, "mid_reset");
    @(negedge CLK);

    // Overflow run: +262144 per cycle starting from 0
    for (int k = 0; k < 11; k++) begin
      set_all(7, 7, 0, 0, 0);
      drive(1'b0, "overflow_run");
      @(negedge CLK);
    end

    // Negative overflow run after a reset
    set_all(0, 0, 0, 0, 0);
    drive(1'b1, "reset2");
    @(negedge CLK);
    for (int k = 0; k < 10; k++) begin
      set_all(7, 7, 1, 0, 0);
      drive(1'b0, "neg_overflow_run");
      @(negedge CLK);
    end

    // Randomized traffic with occasional resets
    for (int k = 0; k < 400; k++) begin
      randomize_lanes();
      drive(($urandom_range(49) == 0), "random");
      @(negedge CLK);
    end

    // Wait, with a bounded number of cycles, for the monitor to drain the queue
    to = 0;
    while (expq.size() > 0 && to < 20) begin
      @(negedge CLK);
      to++;
    end
    if (expq.size() > 0) begin
      errors++;
      $display("FAIL drain: pending %0d expected 0", expq.size());
    end
    done = 1'b1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
